sync_fifo_wr_arbiter: RTL and testbench

//  Round-robin write arbiter sharing one sync_fifo write port (wr_en/data_in/full) among N_REQ producers.

---
 rtl/sync_fifo_wr_arbiter_pkg.sv | 23 ++
 rtl/sync_fifo_wr_arbiter_rr_pick.sv | 30 +++
 rtl/sync_fifo_wr_arbiter.sv | 153 +++++++++++++++
 tb/tb_sync_fifo_wr_arbiter.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sync_fifo_wr_arbiter_pkg.sv
// Shared types and helpers for the sync_fifo round-robin write arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  localparam int STAT_W = 16;

  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r++;
      x = x >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sync_fifo_wr_arbiter_rr_pick.sv
// Circular priority picker: first candidate at/after i_start, skipping excluded bits.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int PTR_W = clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [PTR_W-1:0] i_start,
  input  logic [N_REQ-1:0] i_excl,
  output logic [N_REQ-1:0] o_gnt,
  output logic             o_vld
);

  logic [N_REQ-1:0] w_cand;

  assign w_cand = i_req & ~i_excl;

  always_comb begin
    o_gnt = '0;
    o_vld = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!o_vld && w_cand[(int'(i_start) + k) % N_REQ]) begin
        o_gnt[(int'(i_start) + k) % N_REQ] = 1'b1;
        o_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sync_fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one sync_fifo write port among N_REQ producers.
// Optional per-producer accept counters are enabled by defining FIFO_ARB_STATS_EN.
module sync_fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  input  logic [N_REQ-1:0]          req_last,
  output logic [N_REQ-1:0]          gnt,
  input  logic                      fifo_full,
  output logic                      fifo_wr_en,
  output logic [DATA_W-1:0]         fifo_data_in,
  output logic                      busy
`ifdef FIFO_ARB_STATS_EN
  ,
  input  logic                      stat_clr,
  output logic [N_REQ*STAT_W-1:0]   stat_cnt
`endif
);

  localparam int CNT_W = clog2(MAX_BURST + 1);
  localparam int PTR_W = clog2(N_REQ);

  arb_state_t       r_state, w_nstate;
  logic [N_REQ-1:0] r_gnt, w_ngnt;
  logic [PTR_W-1:0] r_ptr, w_nptr;
  logic [CNT_W-1:0] r_cnt, w_ncnt;
  logic             r_busy;

  logic [PTR_W-1:0]  w_owner;
  logic [PTR_W-1:0]  w_ptr_inc;
  logic [DATA_W-1:0] w_data;
  logic              w_owner_req;
  logic              w_owner_last;
  logic              w_acc;
  logic              w_release;
  logic [PTR_W-1:0]  w_start;
  logic [N_REQ-1:0]  w_excl;
  logic [N_REQ-1:0]  w_pick;
  logic              w_pick_vld;

  always_comb begin
    w_owner = '0;
    w_data  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (r_gnt[i]) begin
        w_owner = PTR_W'(i);
        w_data  = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign w_owner_req  = |(r_gnt & req);
  assign w_owner_last = |(r_gnt & req_last);
  assign w_acc        = w_owner_req & ~fifo_full;
  assign w_ptr_inc    = (w_owner == PTR_W'(N_REQ - 1)) ? '0 : w_owner + PTR_W'(1);

  // A withdrawn request releases even while the FIFO is full; a full FIFO otherwise freezes the burst.
  assign w_release = (r_state == GRANT) &&
                     ((w_acc && (w_owner_last || r_cnt == CNT_W'(MAX_BURST - 1))) || !w_owner_req);

  assign w_start = (r_state == GRANT) ? w_ptr_inc : r_ptr;
  assign w_excl  = (r_state == GRANT) ? r_gnt : '0;

  rr_pick #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_pick (
    .i_req   (req),
    .i_start (w_start),
    .i_excl  (w_excl),
    .o_gnt   (w_pick),
    .o_vld   (w_pick_vld)
  );

  always_comb begin
    w_nstate = r_state;
    w_ngnt   = r_gnt;
    w_nptr   = r_ptr;
    w_ncnt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (w_pick_vld) begin
          w_nstate = GRANT;
          w_ngnt   = w_pick;
          w_ncnt   = '0;
        end
      end
      GRANT: begin
        if (w_release) begin
          w_nptr = w_ptr_inc;
          w_ncnt = '0;
          if (w_pick_vld) begin
            w_ngnt = w_pick;
          end else if (!w_owner_req) begin
            w_ngnt   = '0;
            w_nstate = IDLE;
          end
        end else if (w_acc) begin
          w_ncnt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_nstate = IDLE;
        w_ngnt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_gnt   <= '0;
      r_ptr   <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_nstate;
      r_gnt   <= w_ngnt;
      r_ptr   <= w_nptr;
      r_cnt   <= w_ncnt;
      r_busy  <= (w_nstate == GRANT);
    end
  end

  assign gnt          = r_gnt;
  assign busy         = r_busy;
  assign fifo_wr_en   = w_acc;
  assign fifo_data_in = w_data;

`ifdef FIFO_ARB_STATS_EN
  for (genvar g = 0; g < N_REQ; g++) begin : g_stat
    logic [STAT_W-1:0] r_stat;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_stat <= '0;
      end else if (stat_clr) begin
        r_stat <= '0;
      end else if (w_acc && r_gnt[g] && r_stat != {STAT_W{1'b1}}) begin
        r_stat <= r_stat + STAT_W'(1);
      end
    end
    assign stat_cnt[g*STAT_W +: STAT_W] = r_stat;
  end
`endif

endmodule

// File: tb/tb_sync_fifo_wr_arbiter.sv
// Scoreboard bench for sync_fifo_wr_arbiter with a behavioural sync_fifo (depth 8) behind it.
module tb_sync_fifo_wr_arbiter;

  localparam int N     = 4;
  localparam int DW    = 8;
  localparam int MB    = 4;
  localparam int DEPTH = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [N-1:0]    req = '0;
  logic [N-1:0]    req_last = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N-1:0]    gnt;
  logic            fifo_full = 1'b0;
  logic            fifo_wr_en;
  logic [DW-1:0]   fifo_data_in;
  logic            busy;
  logic            rd_en = 1'b0;
`ifdef FIFO_ARB_STATS_EN
  logic            stat_clr = 1'b0;
  logic [N*16-1:0] stat_cnt;
`endif

  sync_fifo_wr_arbiter #(
    .N_REQ     (N),
    .DATA_W    (DW),
    .MAX_BURST (MB)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .req_data     (req_data),
    .req_last     (req_last),
    .gnt          (gnt),
    .fifo_full    (fifo_full),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_data_in (fifo_data_in),
    .busy         (busy)
`ifdef FIFO_ARB_STATS_EN
    ,
    .stat_clr     (stat_clr),
    .stat_cnt     (stat_cnt)
`endif
  );

  always #10 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [8:0]     pmem [N][64];
  int             head [N];
  int             tail [N];
  int             pend = -1;
  logic [11:0]    expq [$];
  logic [DW-1:0]  fq [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req_v);
    checks++;
    if (act !== req_v) begin
      errors++;
      $display("FAIL %s: actual %0h, required %0h", name, act, req_v);
    end
  endtask

  task automatic load(input int p, input logic [7:0] d, input logic last);
    pmem[p][tail[p]] = {last, d};
    tail[p]++;
  endtask

  task automatic expect_w(input int p, input logic [7:0] d);
    logic [3:0] oh;
    oh    = '0;
    oh[p] = 1'b1;
    expq.push_back({oh, d});
  endtask

  task automatic do_reset();
    chk("scoreboard drained", 64'(expq.size()), 64'd0);
    rst   = 1'b1;
    rd_en = 1'b0;
    for (int i = 0; i < N; i++) begin
      head[i] = 0;
      tail[i] = 0;
    end
    fq.delete();
    fifo_full = 1'b0;
    repeat (2) @(negedge clk);
    #4;
    rst = 1'b0;
    #1;
  endtask

  // Producers: present queue head, pop it the cycle after it was accepted.
  initial begin
    for (int i = 0; i < N; i++) begin
      head[i] = 0;
      tail[i] = 0;
    end
    forever begin
      @(negedge clk);
      if (rst) pend = -1;
      if (pend >= 0 && head[pend] < tail[pend]) head[pend]++;
      pend = -1;
      for (int i = 0; i < N; i++) begin
        if (head[i] < tail[i]) begin
          req[i]             = 1'b1;
          req_data[i*DW +: DW] = pmem[i][head[i]][7:0];
          req_last[i]        = pmem[i][head[i]][8];
        end else begin
          req[i]             = 1'b0;
          req_data[i*DW +: DW] = '0;
          req_last[i]        = 1'b0;
        end
      end
      #1;
      if (!rst) begin
        for (int i = 0; i < N; i++)
          if (gnt[i] && req[i] && !fifo_full) pend = i;
      end
    end
  end

  // Behavioural sync_fifo: sample intent mid-cycle, commit just after the rising edge.
  initial begin
    logic          w, r, fb;
    logic [DW-1:0] d;
    forever begin
      @(negedge clk);
      #3;
      w = fifo_wr_en;
      r = rd_en;
      d = fifo_data_in;
      @(posedge clk);
      #1;
      if (rst) begin
        fq.delete();
      end else begin
        fb = (fq.size() == DEPTH);
        if (r && fq.size() > 0) void'(fq.pop_front());
        if (w && !fb) fq.push_back(d);
      end
      fifo_full = (fq.size() == DEPTH);
    end
  end

  // Monitor: every FIFO write must match the next expected {grant, word}.
  initial begin
    logic [11:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (!$onehot0(gnt)) begin
        checks++;
        errors++;
        $display("FAIL gnt_onehot: actual %b, required at most one bit", gnt);
      end
      if (fifo_wr_en) begin
        checks++;
        if (fifo_full) begin
          errors++;
          $display("FAIL wr_while_full: actual wr_en=1, required 0");
        end else if (expq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write: actual gnt=%b data=%0h, required no write", gnt, fifo_data_in);
        end else begin
          e = expq.pop_front();
          if ({gnt, fifo_data_in} !== e) begin
            errors++;
            $display("FAIL write: actual gnt=%b data=%0h, required gnt=%b data=%0h",
                     gnt, fifo_data_in, e[11:8], e[7:0]);
          end
        end
      end
    end
  end

  initial begin
    #1 rst = 1'b1;
    #4;
    chk("reset gnt", 64'(gnt), 64'd0);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset wr_en", 64'(fifo_wr_en), 64'd0);
    chk("reset data_in", 64'(fifo_data_in), 64'd0);
    do_reset();

    // Single producer, last on third word.
    for (int n = 1; n <= 3; n++) begin
      load(0, 8'(n), n == 3);
      expect_w(0, 8'(n));
    end
    @(negedge clk); #4;
    chk("t1 gnt before grant", 64'(gnt), 64'd0);
    @(negedge clk); #4;
    chk("t1 gnt", 64'(gnt), 64'b0001);
    chk("t1 busy", 64'(busy), 64'd1);
    repeat (4) @(negedge clk); #4;
    chk("t1 idle gnt", 64'(gnt), 64'd0);
    chk("t1 idle busy", 64'(busy), 64'd0);
    chk("t1 fifo entries", 64'(fq.size()), 64'd3);
    do_reset();

    // All four request continuously: two full rotations, no gap cycles.
    rd_en = 1'b1;
    for (int r = 0; r < 2; r++)
      for (int p = 0; p < N; p++)
        for (int k = 0; k < MB; k++) begin
          load(p, 8'(p*16 + r*4 + k), 1'b0);
          expect_w(p, 8'(p*16 + r*4 + k));
        end
    repeat (33) @(negedge clk); #3;
    chk("t2 32 words in 32 cycles", 64'(expq.size()), 64'd0);
    repeat (4) @(negedge clk); #4;
    chk("t2 idle gnt", 64'(gnt), 64'd0);
    do_reset();

    // Sixteen words into a depth-8 FIFO with no reads, then drain.
    for (int k = 0; k < 16; k++) begin
      load(2, 8'(8'h40 + k), 1'b0);
      expect_w(2, 8'(8'h40 + k));
    end
    repeat (21) @(negedge clk); #4;
    chk("t3 fifo full count", 64'(fq.size()), 64'd8);
    chk("t3 gnt held", 64'(gnt), 64'b0100);
    chk("t3 busy held", 64'(busy), 64'd1);
    chk("t3 wr_en stalled", 64'(fifo_wr_en), 64'd0);
    chk("t3 words pending", 64'(expq.size()), 64'd8);
    rd_en = 1'b1;
    repeat (20) @(negedge clk); #4;
    chk("t3 all written", 64'(expq.size()), 64'd0);
    chk("t3 idle gnt", 64'(gnt), 64'd0);
    chk("t3 idle busy", 64'(busy), 64'd0);
    do_reset();

    // Producer 1 withdraws after two words while producer 3 waits.
    load(1, 8'h11, 1'b0); load(1, 8'h12, 1'b0);
    for (int k = 0; k < 5; k++) load(3, 8'(8'h31 + k), 1'b0);
    expect_w(1, 8'h11); expect_w(1, 8'h12);
    for (int k = 0; k < 4; k++) expect_w(3, 8'(8'h31 + k));
    expect_w(0, 8'h01);
    expect_w(3, 8'h35);
    repeat (4) @(negedge clk); #4;
    chk("t4 withdraw cycle gnt", 64'(gnt), 64'b0010);
    chk("t4 withdraw cycle wr_en", 64'(fifo_wr_en), 64'd0);
    @(negedge clk); #4;
    chk("t4 gnt moves to 3", 64'(gnt), 64'b1000);
    load(0, 8'h01, 1'b1);
    repeat (10) @(negedge clk); #4;
    chk("t4 sequence done", 64'(expq.size()), 64'd0);
    do_reset();

    // Reset in the middle of a burst.
    for (int k = 0; k < 4; k++) load(2, 8'(8'h51 + k), 1'b0);
    expect_w(2, 8'h51); expect_w(2, 8'h52);
    repeat (3) @(negedge clk); #4;
    rst = 1'b1;
    #1;
    chk("t5 reset gnt", 64'(gnt), 64'd0);
    chk("t5 reset busy", 64'(busy), 64'd0);
    chk("t5 reset wr_en", 64'(fifo_wr_en), 64'd0);
    @(posedge clk); #2;
    chk("t5 fifo emptied", 64'(fq.size()), 64'd0);
    do_reset();

`ifdef FIFO_ARB_STATS_EN
    for (int k = 0; k < 5; k++) load(0, 8'(8'h61 + k), 1'b0);
    for (int k = 0; k < 3; k++) load(2, 8'(8'h71 + k), k == 2);
    for (int k = 0; k < 4; k++) expect_w(0, 8'(8'h61 + k));
    for (int k = 0; k < 3; k++) expect_w(2, 8'(8'h71 + k));
    expect_w(0, 8'h65);
    repeat (12) @(negedge clk); #4;
    chk("t6 sequence done", 64'(expq.size()), 64'd0);
    chk("t6 stat_cnt", 64'(stat_cnt), {16'd0, 16'd3, 16'd0, 16'd5});
    stat_clr = 1'b1;
    @(negedge clk); #4;
    stat_clr = 1'b0;
    chk("t6 stat_cnt cleared", 64'(stat_cnt), 64'd0);
    do_reset();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
